// File: rtl/dma_host.sv
// dma_host: single-channel word-copy DMA engine with a register config port and a host initiator port.
// Define DMA_IRQ_EN to enable the IRQ_EN control bit and the level interrupt on dma_intr_o.
module dma_host #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dma_req_i,
  input  logic                    dma_we_i,
  input  logic [3:0]              dma_be_i,
  input  logic [31:0]             dma_addr_i,
  input  logic [DataWidth-1:0]    dma_wdata_i,
  output logic                    dma_rvalid_o,
  output logic [DataWidth-1:0]    dma_rdata_o,
  output logic                    dma_err_o,
  output logic                    host_req_o,
  output logic                    host_we_o,
  output logic [3:0]              host_be_o,
  output logic [AddressWidth-1:0] host_addr_o,
  output logic [DataWidth-1:0]    host_wdata_o,
  input  logic                    host_gnt_i,
  input  logic                    host_rvalid_i,
  input  logic                    host_err_i,
  input  logic [DataWidth-1:0]    host_rdata_i,
  output logic                    dma_intr_o
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

  state_e                  r_state;
  logic [AddressWidth-1:0] r_src, r_dst, r_wsrc, r_wdst;
  logic [15:0]             r_len, r_cnt;
  logic                    r_done, r_err;
  logic                    r_rvalid, r_cerr;
  logic [DataWidth-1:0]    r_rdata;
  logic                    r_host_req, r_host_we;
  logic [3:0]              r_host_be;
  logic [AddressWidth-1:0] r_host_addr;
  logic [DataWidth-1:0]    r_buf;

  logic [7:0]           w_off;
  logic                 w_busy, w_hit, w_lock, w_cfg_err, w_wr, w_start, w_irq_en;
  logic [DataWidth-1:0] w_rd;
  logic                 w_unused;

  assign w_off    = dma_addr_i[7:0];
  assign w_busy   = (r_state != IDLE);
  assign w_unused = ^{dma_be_i, dma_addr_i[31:8]};

`ifdef DMA_IRQ_EN
  logic r_irq_en;
  assign w_irq_en   = r_irq_en;
  assign dma_intr_o = r_done & r_irq_en;
`else
  assign w_irq_en   = 1'b0;
  assign dma_intr_o = 1'b0;
`endif

  // SRC/DST/LEN are locked against writes while a transfer runs; reads stay allowed.
  always_comb begin
    w_rd   = '0;
    w_hit  = 1'b1;
    w_lock = 1'b0;
    case (w_off)
      8'h00: begin w_rd = DataWidth'(r_src); w_lock = w_busy; end
      8'h04: begin w_rd = DataWidth'(r_dst); w_lock = w_busy; end
      8'h08: begin w_rd = DataWidth'(r_len); w_lock = w_busy; end
      8'h0C: w_rd = DataWidth'({w_irq_en, 1'b0});
      8'h10: w_rd = DataWidth'({r_err, r_done, w_busy});
      default: w_hit = 1'b0;
    endcase
  end

  assign w_cfg_err = !w_hit || (dma_we_i && w_lock);
  assign w_wr      = dma_req_i && dma_we_i && !w_cfg_err;
  assign w_start   = w_wr && (w_off == 8'h0C) && dma_wdata_i[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_cerr   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= dma_req_i;
      r_cerr   <= dma_req_i && w_cfg_err;
      r_rdata  <= (dma_req_i && !dma_we_i && !w_cfg_err) ? w_rd : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
`ifdef DMA_IRQ_EN
      r_irq_en <= 1'b0;
`endif
    end else if (w_wr) begin
      case (w_off)
        8'h00: r_src <= AddressWidth'({dma_wdata_i[DataWidth-1:2], 2'b00});
        8'h04: r_dst <= AddressWidth'({dma_wdata_i[DataWidth-1:2], 2'b00});
        8'h08: r_len <= dma_wdata_i[15:0];
`ifdef DMA_IRQ_EN
        8'h0C: r_irq_en <= dma_wdata_i[1];
`endif
        default: ;
      endcase
    end
  end

  // STATUS W1C is applied before the engine update so a completion in the same cycle is not lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_wsrc      <= '0;
      r_wdst      <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_host_req  <= 1'b0;
      r_host_we   <= 1'b0;
      r_host_be   <= '0;
      r_host_addr <= '0;
      r_buf       <= '0;
    end else begin
      if (w_wr && (w_off == 8'h10)) begin
        if (dma_wdata_i[1]) r_done <= 1'b0;
        if (dma_wdata_i[2]) r_err  <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_err <= 1'b0;
            if (r_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_done      <= 1'b0;
              r_wsrc      <= r_src;
              r_wdst      <= r_dst;
              r_cnt       <= r_len;
              r_host_req  <= 1'b1;
              r_host_we   <= 1'b0;
              r_host_be   <= '1;
              r_host_addr <= r_src;
              r_state     <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (host_gnt_i) begin
            r_host_req <= 1'b0;
            r_host_be  <= '0;
            r_state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (host_rvalid_i) begin
            if (host_err_i) begin
              r_err   <= 1'b1;
              r_done  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_buf       <= host_rdata_i;
              r_host_req  <= 1'b1;
              r_host_we   <= 1'b1;
              r_host_be   <= '1;
              r_host_addr <= r_wdst;
              r_state     <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (host_gnt_i) begin
            r_host_req <= 1'b0;
            r_host_we  <= 1'b0;
            r_host_be  <= '0;
            r_state    <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (host_rvalid_i) begin
            if (host_err_i) begin
              r_err   <= 1'b1;
              r_done  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_wsrc <= r_wsrc + AddressWidth'(4);
              r_wdst <= r_wdst + AddressWidth'(4);
              r_cnt  <= r_cnt - 16'd1;
              if (r_cnt == 16'd1) begin
                r_done  <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_host_req  <= 1'b1;
                r_host_we   <= 1'b0;
                r_host_be   <= '1;
                r_host_addr <= r_wsrc + AddressWidth'(4);
                r_state     <= RD_REQ;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dma_rvalid_o = r_rvalid;
  assign dma_rdata_o  = r_rdata;
  assign dma_err_o    = r_cerr;
  assign host_req_o   = r_host_req;
  assign host_we_o    = r_host_we;
  assign host_be_o    = r_host_be;
  assign host_addr_o  = r_host_addr;
  assign host_wdata_o = r_buf;

endmodule

// File: tb/tb_dma_host.sv
// Bench for dma_host: register vector table, directed multi-cycle sequences, and randomized copies
// checked against a word-list copy model and a RAM responder.
`timescale 1ns/1ps
module tb_dma_host;

  logic        clk, rst_n;
  logic        dma_req, dma_we;
  logic [3:0]  dma_be;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_rvalid, dma_err;
  logic [31:0] dma_rdata;
  logic        host_req, host_we;
  logic [3:0]  host_be;
  logic [31:0] host_addr, host_wdata;
  logic        host_gnt, host_rvalid, host_err;
  logic [31:0] host_rdata;
  logic        intr;

  dma_host #(.DataWidth(32), .AddressWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_be_i(dma_be),
    .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rvalid_o(dma_rvalid), .dma_rdata_o(dma_rdata), .dma_err_o(dma_err),
    .host_req_o(host_req), .host_we_o(host_we), .host_be_o(host_be),
    .host_addr_o(host_addr), .host_wdata_o(host_wdata),
    .host_gnt_i(host_gnt), .host_rvalid_i(host_rvalid), .host_err_i(host_err),
    .host_rdata_i(host_rdata), .dma_intr_o(intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DMA_IRQ_EN
  localparam bit IrqBuild = 1'b1;
`else
  localparam bit IrqBuild = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // RAM responder model
  typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } txn_t;
  txn_t        obs[$];
  bit   [31:0] mem [bit [31:0]];
  logic [31:0] exp_src[$], exp_dst[$];
  int          gnt_delay = 0, gnt_cnt = 0, resp_idx = 0, err_at = -1;
  int unsigned cyc = 0, first_req_cyc = 0, last_rsp_cyc = 0, proto_viol = 0;
  bit          seen_req = 0;
  logic        p_req, p_we;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_be;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  initial begin
    host_gnt = 1'b0; host_rvalid = 1'b0; host_err = 1'b0; host_rdata = '0;
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0; p_be = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      host_rvalid = 1'b0; host_err = 1'b0; host_rdata = '0;
      if (p_req && host_gnt) begin
        obs.push_back('{p_we, p_addr, p_wdata});
        host_rvalid  = 1'b1;
        last_rsp_cyc = cyc;
        host_err     = (err_at >= 0) && (resp_idx == err_at);
        if (!host_err) begin
          if (p_we) mem[p_addr] = p_wdata;
          else host_rdata = rd_mem(p_addr);
        end
        resp_idx++;
        if (host_req) proto_viol++;
      end else if (p_req) begin
        if (!host_req || host_addr !== p_addr || host_we !== p_we ||
            host_wdata !== p_wdata || host_be !== p_be) proto_viol++;
      end
      host_gnt = 1'b0;
      if (!rst_n) gnt_cnt = 0;
      else if (host_req) begin
        if (!seen_req) begin seen_req = 1'b1; first_req_cyc = cyc; end
        if (host_be !== 4'hF) proto_viol++;
        if (gnt_cnt >= gnt_delay) begin host_gnt = 1'b1; gnt_cnt = 0; end
        else gnt_cnt++;
      end
      p_req = host_req; p_we = host_we; p_addr = host_addr; p_wdata = host_wdata; p_be = host_be;
    end
  end

  task automatic clear_bus();
    obs.delete();
    resp_idx = 0; err_at = -1; seen_req = 1'b0; proto_viol = 0;
  endtask

  task automatic cfg(input bit we, input logic [7:0] off, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er);
    logic [31:0] hi;
    hi        = $urandom;
    dma_req   = 1'b1;
    dma_we    = we;
    dma_addr  = {hi[31:8], off};
    dma_wdata = wd;
    dma_be    = 4'($urandom);
    @(posedge clk); #1;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_be = '0;
    chk("cfg_rvalid", 32'(dma_rvalid), 32'd1);
    rd = dma_rdata;
    er = dma_err;
  endtask

  task automatic wait_idle(output logic [31:0] st);
    logic e;
    st = 32'h1;
    for (int i = 0; i < 400 && st[0]; i++) cfg(1'b0, 8'h10, 32'h0, st, e);
    chk("busy_timeout", 32'(st[0]), 32'd0);
  endtask

  task automatic seed(input logic [31:0] s, input logic [31:0] d, input int len);
    exp_src.delete(); exp_dst.delete();
    for (int w = 0; w < len; w++) begin
      exp_src.push_back($urandom);
      exp_dst.push_back($urandom);
      mem[s + 32'(4*w)] = exp_src[w];
      mem[d + 32'(4*w)] = exp_dst[w];
    end
  endtask

  task automatic start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len, input bit irq);
    logic [31:0] rd;
    logic        e;
    cfg(1'b1, 8'h00, s, rd, e);
    cfg(1'b1, 8'h04, d, rd, e);
    cfg(1'b1, 8'h08, {16'h0, len}, rd, e);
    clear_bus();
    cfg(1'b1, 8'h0C, {30'h0, irq, 1'b1}, rd, e);
  endtask

  // Model: word w is read from s+4w then written to d+4w; an errored response ends the list there.
  task automatic check_transfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                                input int len, input int ea, input logic [31:0] st);
    int          n_txn, done_w;
    logic [31:0] a;
    n_txn  = (ea < 0) ? 2*len : ea + 1;
    done_w = (ea < 0) ? len : ea / 2;
    chk({tag, "_ntxn"}, 32'(obs.size()), 32'(n_txn));
    for (int i = 0; i < n_txn && i < obs.size(); i++) begin
      a = ((i % 2) == 1) ? d + 32'(4*(i/2)) : s + 32'(4*(i/2));
      chk($sformatf("%s_t%0d_addr", tag, i), obs[i].addr, a);
      chk($sformatf("%s_t%0d_we", tag, i), 32'(obs[i].we), 32'(i % 2));
      if ((i % 2) == 1) chk($sformatf("%s_t%0d_data", tag, i), obs[i].data, exp_src[i/2]);
    end
    for (int w = 0; w < len; w++)
      chk($sformatf("%s_mem%0d", tag, w), rd_mem(d + 32'(4*w)), (w < done_w) ? exp_src[w] : exp_dst[w]);
    chk({tag, "_status"}, st, (ea < 0) ? 32'h2 : 32'h4);
    chk({tag, "_proto"}, 32'(proto_viol), 32'd0);
  endtask

  typedef struct { bit we; logic [7:0] off; logic [31:0] wdata; logic [31:0] exp_rd; bit exp_err; } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] rd, st, s, d;
    logic        e;
    int          len;

    rst_n = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_be = '0; dma_addr = '0; dma_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_host_req", 32'(host_req), 32'd0);
    chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rst_rdata", dma_rdata, 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_host_addr", host_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b1, 8'h00, 32'h1234_5677, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h1234_5674, 1'b0});
    vecs.push_back('{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 8'h04, 32'h0,         32'hFFFF_FFFC, 1'b0});
    vecs.push_back('{1'b1, 8'h08, 32'hABCD_0005, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 8'h08, 32'h0,         32'h0000_0005, 1'b0});
    vecs.push_back('{1'b1, 8'h0C, 32'h0000_0002, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 8'h0C, 32'h0,         IrqBuild ? 32'h2 : 32'h0, 1'b0});
    vecs.push_back('{1'b1, 8'h10, 32'h0000_0007, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 8'h10, 32'h0,         32'h0,         1'b0});
    vecs.push_back('{1'b0, 8'h20, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{1'b1, 8'h14, 32'hFFFF_FFFF, 32'h0,         1'b1});
    vecs.push_back('{1'b1, 8'h0C, 32'h0,         32'h0,         1'b0});
    foreach (vecs[i]) begin
      cfg(vecs[i].we, vecs[i].off, vecs[i].wdata, rd, e);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
    end
    @(posedge clk); #1;
    chk("idle_rvalid", 32'(dma_rvalid), 32'd0);
    chk("idle_rdata", dma_rdata, 32'd0);
    chk("idle_err", 32'(dma_err), 32'd0);

    // Zero-wait 4-word copy: 16 cycles from first request to last response
    gnt_delay = 0;
    seed(32'h0010_0000, 32'h0010_0400, 4);
    start(32'h0010_0000, 32'h0010_0400, 16'd4, 1'b0);
    wait_idle(st);
    check_transfer("copy4", 32'h0010_0000, 32'h0010_0400, 4, -1, st);
    chk("copy4_cycles", last_rsp_cyc - first_req_cyc + 1, 32'd16);

    // LEN=0: DONE without bus traffic
    start(32'h0000_2000, 32'h0000_3000, 16'd0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    chk("len0_noreq", 32'(seen_req), 32'd0);
    cfg(1'b0, 8'h10, 32'h0, rd, e);
    chk("len0_status", rd, 32'h2);

    // Grant held off 5 cycles per request
    gnt_delay = 5;
    seed(32'h0000_5000, 32'h0000_6000, 2);
    start(32'h0000_5000, 32'h0000_6000, 16'd2, 1'b0);
    wait_idle(st);
    check_transfer("gntwait", 32'h0000_5000, 32'h0000_6000, 2, -1, st);

    // Error on second read response of a 3-word copy
    gnt_delay = 0;
    seed(32'h0000_7000, 32'h0000_8000, 3);
    start(32'h0000_7000, 32'h0000_8000, 16'd3, 1'b0);
    err_at = 2;
    wait_idle(st);
    repeat (10) begin @(posedge clk); #1; end
    check_transfer("abort", 32'h0000_7000, 32'h0000_8000, 3, 2, st);
    cfg(1'b1, 8'h10, 32'h4, rd, e);
    cfg(1'b0, 8'h10, 32'h0, rd, e);
    chk("abort_w1c", rd, 32'h0);

    // Config accesses while busy
    gnt_delay = 3;
    seed(32'h0000_9000, 32'h0000_A000, 8);
    start(32'h0000_9000, 32'h0000_A000, 16'd8, 1'b0);
    cfg(1'b0, 8'h10, 32'h0, rd, e);
    chk("busy_status", rd, 32'h1);
    cfg(1'b1, 8'h08, 32'h55, rd, e);
    chk("busy_len_wr_err", 32'(e), 32'd1);
    cfg(1'b0, 8'h20, 32'h0, rd, e);
    chk("busy_unmapped_err", 32'(e), 32'd1);
    cfg(1'b1, 8'h00, 32'h1000, rd, e);
    chk("busy_src_wr_err", 32'(e), 32'd1);
    cfg(1'b1, 8'h0C, 32'h1, rd, e);
    chk("busy_start_noerr", 32'(e), 32'd0);
    cfg(1'b0, 8'h08, 32'h0, rd, e);
    chk("busy_len_kept", rd, 32'd8);
    chk("busy_len_rd_noerr", 32'(e), 32'd0);
    wait_idle(st);
    check_transfer("busy", 32'h0000_9000, 32'h0000_A000, 8, -1, st);

    // Interrupt follows DONE and clears on W1C
    gnt_delay = 0;
    seed(32'h0000_B000, 32'h0000_C000, 1);
    start(32'h0000_B000, 32'h0000_C000, 16'd1, 1'b1);
    chk("irq_low_busy", 32'(intr), 32'd0);
    wait_idle(st);
    chk("irq_status", st, 32'h2);
    chk("irq_high", 32'(intr), 32'(IrqBuild));
    cfg(1'b1, 8'h10, 32'h2, rd, e);
    chk("irq_cleared", 32'(intr), 32'd0);
    cfg(1'b0, 8'h10, 32'h0, rd, e);
    chk("irq_status_clr", rd, 32'h0);

    // Randomized copies with random grant delay and occasional error injection
    for (int t = 0; t < 20; t++) begin
      s = (t == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      d = s + 32'h1000;
      len = $urandom_range(1, 6);
      gnt_delay = $urandom_range(0, 3);
      seed(s, d, len);
      start(s, d, 16'(len), 1'b0);
      err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2*len - 1) : -1;
      wait_idle(st);
      check_transfer($sformatf("rnd%0d", t), s, d, len, err_at, st);
    end

    // Asynchronous reset in the middle of a transfer
    gnt_delay = 2;
    seed(32'h0000_D000, 32'h0000_E000, 4);
    start(32'h0000_D000, 32'h0000_E000, 16'd4, 1'b0);
    for (int i = 0; i < 20 && !host_req; i++) begin @(posedge clk); #1; end
    chk("mid_req_seen", 32'(host_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(host_req), 32'd0);
    chk("mid_rst_addr", host_addr, 32'd0);
    chk("mid_rst_we", 32'(host_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfg(1'b0, 8'h10, 32'h0, rd, e);
    chk("post_rst_status", rd, 32'h0);
    cfg(1'b0, 8'h00, 32'h0, rd, e);
    chk("post_rst_src", rd, 32'h0);
    chk("post_rst_noreq", 32'(host_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_host.md
DMA_HOST -- requirements
Module: dma_host

Interface
REQ-001 SHALL have parameter DataWidth, default 32, bus data width; only 32 is supported.
REQ-002 SHALL have parameter AddressWidth, default 32, bus address width.
REQ-003 SHALL have port clk_i  input  1  system clock; the block uses this one clock only.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have config responder ports dma_req_i/dma_we_i (in, 1), dma_be_i (in, 4), dma_addr_i/dma_wdata_i (in, 32): register access from the bus.
REQ-006 SHALL have config response ports dma_rvalid_o (out, 1), dma_rdata_o (out, 32), dma_err_o (out, 1).
REQ-007 SHALL have host initiator outputs host_req_o/host_we_o (1), host_be_o (4), host_addr_o/host_wdata_o (32): bus requests issued by the engine.
REQ-008 SHALL have host inputs host_gnt_i/host_rvalid_i/host_err_i (1), host_rdata_i (32): bus grant and response.
REQ-009 SHALL have port dma_intr_o  output  1  transfer-complete interrupt, level.

Function
REQ-010 Register map (offset = dma_addr_i[7:0]): 0x00 SRC, 0x04 DST, 0x08 LEN[15:0] (words), 0x0C CTRL (bit0 START write-only, reads 0; bit1 IRQ_EN), 0x10 STATUS (bit0 BUSY, bit1 DONE, bit2 ERR; W1C on bits 1-2).
REQ-011 Config access SHALL answer with dma_rvalid_o exactly one cycle after dma_req_i, for reads and writes; dma_rdata_o valid only then, else 0.
REQ-012 Unmapped offset, or write to SRC/DST/LEN while BUSY, SHALL be ignored and raise dma_err_o with dma_rvalid_o.
REQ-013 SRC/DST bits [1:0] SHALL be stored as 0; dma_be_i SHALL be ignored (full-word registers).
REQ-014 FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
REQ-015 START=1 in IDLE with LEN!=0: load working src/dst/count, set BUSY, clear DONE/ERR, enter RD_REQ next cycle.
REQ-016 START in IDLE with LEN=0: set DONE immediately, no bus traffic; START while BUSY ignored, no error.
REQ-017 RD_REQ: host_req_o=1, host_we_o=0, host_be_o=4'hF, host_addr_o=src; held stable until host_gnt_i, then RD_WAIT.
REQ-018 RD_WAIT: on host_rvalid_i capture host_rdata_i into data buffer, go WR_REQ.
REQ-019 WR_REQ: host_req_o=1, host_we_o=1, host_be_o=4'hF, addr=dst, wdata=buffer; held until host_gnt_i, then WR_WAIT.
REQ-020 WR_WAIT: on host_rvalid_i src+=4, dst+=4 (mod 2^32 wrap), count-=1; count reaching 0 -> IDLE, BUSY=0, DONE=1; else RD_REQ.
REQ-021 host_req_o SHALL be 0 in IDLE, RD_WAIT, WR_WAIT; at most one outstanding transaction.
REQ-022 host_err_i sampled with host_rvalid_i SHALL abort to IDLE: BUSY=0, ERR=1, DONE=0, no further requests.
REQ-023 Config access and engine run concurrently; STATUS reads during transfer return live BUSY.
REQ-024 Minimum per-word cost with zero-wait bus (gnt same cycle, rvalid next): 4 cycles.

Reset
REQ-025 On rst_ni low, all outputs 0, registers 0, FSM IDLE, immediately regardless of clk_i, including mid-transfer (transaction dropped).

Configuration
REQ-026 With DMA_IRQ_EN defined: dma_intr_o = DONE & IRQ_EN, cleared by W1C of DONE.
REQ-027 Without DMA_IRQ_EN: dma_intr_o tied 0, CTRL bit1 not stored and reads 0.

Verification
REQ-028 SRC=0x100000, DST=0x100400, LEN=4, START, zero-wait RAM -> four read/write pairs, DST words equal SRC, DONE=1 after 16 cycles of bus activity.
REQ-029 LEN=0, START -> no host_req_o, STATUS reads 0x2 next access.
REQ-030 host_gnt_i held low 5 cycles during RD_REQ -> host_req_o/addr stable all 5 cycles, transfer completes correctly.
REQ-031 host_err_i=1 on second read response of LEN=3 -> STATUS=0x4, exactly one write issued, no further requests.
REQ-032 Write LEN during BUSY and read offset 0x20 -> dma_err_o=1 both, LEN unchanged.
REQ-033 DMA_IRQ_EN, IRQ_EN=1, LEN=1 -> dma_intr_o rises with DONE, falls after STATUS write 0x2; rst_ni low mid-transfer -> host_req_o=0 same cycle.
